gesture_classify: RTL and testbench

//  Downstream of the binary-image bounding-box/fingertip stage. Once per frame it takes that stage's box
//  (x/y min/max), area and fingertip metric, and classifies the hand as NONE/FIST/PALM/POINT.
//  It debounces the class over consecutive frames and forces NONE after a run of frames with no result.

---
 rtl/gesture_classify_pkg.sv | 21 ++
 rtl/gesture_classify_if.sv | 26 ++
 rtl/gesture_classify_debounce.sv | 85 ++++++++
 rtl/gesture_classify.sv | 143 ++++++++++++++
 tb/tb_gesture_classify.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gesture_classify_pkg.sv
// Shared types and widths for the gesture classifier.
//   gest_e    : class codes driven on gesture_code (4-7 unused)
//   *W        : bus widths used by the interface, the top and the debouncer
package gesture_classify_pkg;

  localparam int unsigned GestW  = 3;
  localparam int unsigned CoordW = 12;
  localparam int unsigned AreaW  = 20;
  localparam int unsigned FtW    = 20;
  localparam int unsigned ProdW  = 16;
  localparam int unsigned TcntW  = 8;
  localparam int unsigned CntW   = 4;

  typedef enum logic [GestW-1:0] {
    GestNone  = 3'd0,
    GestFist  = 3'd1,
    GestPalm  = 3'd2,
    GestPoint = 3'd3
  } gest_e;

endpackage

// File: rtl/gesture_classify_if.sv
// Per-frame result bus from the bounding-box/fingertip stage.
//   box_valid          : 1-cycle strobe, fields below valid in that cycle
//   x_min/x_max        : box column bounds
//   y_min/y_max        : box row bounds
//   box_area           : box area, carried through for the report
//   fingertip          : area/perimeter metric
// master drives the bus, slave (the classifier) receives it.
interface gesture_classify_if;

  logic                                     box_valid;
  logic [gesture_classify_pkg::CoordW-1:0]  x_min;
  logic [gesture_classify_pkg::CoordW-1:0]  x_max;
  logic [gesture_classify_pkg::CoordW-1:0]  y_min;
  logic [gesture_classify_pkg::CoordW-1:0]  y_max;
  logic [gesture_classify_pkg::AreaW-1:0]   box_area;
  logic [gesture_classify_pkg::FtW-1:0]     fingertip;

  modport master (
    output box_valid, x_min, x_max, y_min, y_max, box_area, fingertip
  );

  modport slave (
    input box_valid, x_min, x_max, y_min, y_max, box_area, fingertip
  );

endinterface

// File: rtl/gesture_classify_debounce.sv
// Debounce stage: holds a candidate class and a run count, and moves
// gesture_code to the candidate once it has been seen STABLE_N times in a row.
//   clk, rst   : clock, synchronous active-high reset
//   cls_valid  : one classified frame this cycle
//   cls        : its class
//   cls_area   : its box area, latched when the code changes
//   timeout    : force NONE (only asserted by the top when no frame is accepted)
//   code       : debounced class
//   change     : 1-cycle pulse when code changes
//   stable     : candidate agrees with code and has a full run behind it
//   area       : box area of the frame that last changed code
module gesture_classify_debounce
  import gesture_classify_pkg::*;
#(
  parameter int unsigned STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cls_valid,
  input  gest_e            cls,
  input  logic [AreaW-1:0] cls_area,
  input  logic             timeout,
  output gest_e            code,
  output logic             change,
  output logic             stable,
  output logic [AreaW-1:0] area
);

  localparam logic [CntW-1:0] StableN = CntW'(STABLE_N);

  gest_e            cand_q, cand_d;
  gest_e            code_q, code_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             change_q, change_d;
  logic [AreaW-1:0] area_q, area_d;

  always_comb begin
    cand_d   = cand_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    change_d = 1'b0;
    area_d   = area_q;
    if (cls_valid) begin
      if (cls == cand_q) begin
        cnt_d = (cnt_q >= StableN) ? StableN : cnt_q + 4'd1;
      end else begin
        cand_d = cls;
        cnt_d  = 4'd1;
      end
      // Decision uses the post-update candidate/count of this frame.
      if ((cnt_d >= StableN) && (cand_d != code_q)) begin
        code_d   = cand_d;
        area_d   = cls_area;
        change_d = 1'b1;
      end
    end else if (timeout) begin
      code_d   = GestNone;
      cand_d   = GestNone;
      cnt_d    = '0;
      change_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q   <= GestNone;
      code_q   <= GestNone;
      cnt_q    <= '0;
      change_q <= 1'b0;
      area_q   <= '0;
    end else begin
      cand_q   <= cand_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
      area_q   <= area_d;
    end
  end

  assign code   = code_q;
  assign change = change_q;
  assign area   = area_q;
  assign stable = (cand_q == code_q) && (cnt_q >= StableN);

endmodule

// File: rtl/gesture_classify.sv
// Hand gesture classifier. Per frame: S1 registers box geometry, S2 classifies
// NONE/FIST/PALM/POINT, S3 (sub-module) debounces. A vsync-driven frame counter
// forces NONE after TIMEOUT_FRM frames without a result.
//   clk, rst        : pixel clock, synchronous active-high reset
//   per_frame_vsync : frame sync, rising edge is the frame tick
//   box             : per-frame result bus (slave)
//   gesture_code    : 0 NONE, 1 FIST, 2 PALM, 3 POINT
//   gesture_change  : 1-cycle pulse on code change
//   gesture_stable  : candidate equals code with a full run
//   gesture_area    : box area of the frame that last changed the code
module gesture_classify
  import gesture_classify_pkg::*;
#(
  parameter int unsigned MIN_DIM     = 40,
  parameter int unsigned POINT_RATIO = 10,
  parameter int unsigned PALM_FT_TH  = 300,
  parameter int unsigned STABLE_N    = 4,
  parameter int unsigned TIMEOUT_FRM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 per_frame_vsync,
  gesture_classify_if.slave    box,
  output logic [GestW-1:0]     gesture_code,
  output logic                 gesture_change,
  output logic                 gesture_stable,
  output logic [AreaW-1:0]     gesture_area
);

  localparam logic [CoordW-1:0] MinDim   = CoordW'(MIN_DIM);
  localparam logic [ProdW-1:0]  Ratio    = ProdW'(POINT_RATIO);
  localparam logic [FtW-1:0]    PalmTh   = FtW'(PALM_FT_TH);
  localparam logic [TcntW-1:0]  TimeoutN = TcntW'(TIMEOUT_FRM);

  // S1: geometry
  logic              box_ok;
  logic [CoordW-1:0] box_w, box_h;
  logic              s1_valid_q, s1_ok_q;
  logic [CoordW-1:0] s1_w_q, s1_h_q;
  logic [FtW-1:0]    s1_ft_q;
  logic [AreaW-1:0]  s1_area_q;

  always_comb begin
    box_ok = (box.x_max > box.x_min) && (box.y_max > box.y_min);
    box_w  = box_ok ? box.x_max - box.x_min : '0;
    box_h  = box_ok ? box.y_max - box.y_min : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ok_q    <= 1'b0;
      s1_w_q     <= '0;
      s1_h_q     <= '0;
      s1_ft_q    <= '0;
      s1_area_q  <= '0;
    end else begin
      s1_valid_q <= box.box_valid;
      s1_ok_q    <= box_ok;
      s1_w_q     <= box_w;
      s1_h_q     <= box_h;
      s1_ft_q    <= box.fingertip;
      s1_area_q  <= box.box_area;
    end
  end

  // S2: classification. h*4 >= w*ratio avoids a divider for the h/w test.
  logic [ProdW-1:0] prod_h, prod_w;
  gest_e            s2_cls_d, s2_cls_q;
  logic             s2_valid_q;
  logic [AreaW-1:0] s2_area_q;

  always_comb begin
    prod_h = {2'b00, s1_h_q, 2'b00};
    prod_w = ProdW'(s1_w_q) * Ratio;
    if (!s1_ok_q || (s1_w_q < MinDim) || (s1_h_q < MinDim)) begin
      s2_cls_d = GestNone;
    end else if (prod_h >= prod_w) begin
      s2_cls_d = GestPoint;
    end else if (s1_ft_q >= PalmTh) begin
      s2_cls_d = GestPalm;
    end else begin
      s2_cls_d = GestFist;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_cls_q   <= GestNone;
      s2_area_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_cls_q   <= s2_cls_d;
      s2_area_q  <= s1_area_q;
    end
  end

  // Frame timeout; an S3 accept always takes priority over vsync and timeout.
  logic             vsync_q, vsync_edge, accept, timeout;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  gest_e            code_w;

  always_comb begin
    vsync_edge = per_frame_vsync & ~vsync_q;
    accept     = s2_valid_q;
    tcnt_d     = tcnt_q;
    if (accept) begin
      tcnt_d = '0;
    end else if (vsync_edge && (tcnt_q < TimeoutN)) begin
      tcnt_d = tcnt_q + 8'd1;
    end
    timeout = (tcnt_q == TimeoutN) && (code_w != GestNone) && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      tcnt_q  <= tcnt_d;
    end
  end

  gesture_classify_debounce #(
    .STABLE_N (STABLE_N)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .cls_valid (s2_valid_q),
    .cls       (s2_cls_q),
    .cls_area  (s2_area_q),
    .timeout   (timeout),
    .code      (code_w),
    .change    (gesture_change),
    .stable    (gesture_stable),
    .area      (gesture_area)
  );

  assign gesture_code = code_w;

endmodule

// File: tb/tb_gesture_classify.sv
// Directed bench for gesture_classify: reset, pipeline latency, a table of
// classification/debounce vectors, frame timeout and accept/vsync collision.
module tb_gesture_classify;
  import gesture_classify_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [2:0]  gesture_code;
  logic        gesture_change;
  logic        gesture_stable;
  logic [19:0] gesture_area;

  gesture_classify_if box_bus ();

  gesture_classify #(
    .MIN_DIM     (40),
    .POINT_RATIO (10),
    .PALM_FT_TH  (300),
    .STABLE_N    (4),
    .TIMEOUT_FRM (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (vsync),
    .box             (box_bus),
    .gesture_code    (gesture_code),
    .gesture_change  (gesture_change),
    .gesture_stable  (gesture_stable),
    .gesture_area    (gesture_area)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;

  always @(negedge clk) if (gesture_change === 1'b1) n_pulse++;

  typedef struct {
    string name;
    int    x0, x1, y0, y1, ft, area, reps;
    int    code, pulses, stable;
  } vec_t;

  function automatic vec_t mk(input string name, input int x0, input int x1, input int y0,
                              input int y1, input int ft, input int area, input int reps,
                              input int code, input int pulses, input int stable);
    vec_t v;
    v.name = name; v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1;
    v.ft = ft; v.area = area; v.reps = reps;
    v.code = code; v.pulses = pulses; v.stable = stable;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frames(input int x0, input int x1, input int y0, input int y1,
                             input int ft, input int area, input int reps);
    for (int i = 0; i < reps; i++) begin
      box_bus.box_valid = 1'b1;
      box_bus.x_min     = 12'(x0);
      box_bus.x_max     = 12'(x1);
      box_bus.y_min     = 12'(y0);
      box_bus.y_max     = 12'(y1);
      box_bus.fingertip = 20'(ft);
      box_bus.box_area  = 20'(area);
      tick();
    end
    box_bus.box_valid = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  vec_t vecs[11];
  int   p0;
  int   exp_area;

  initial begin
    vecs[0]  = mk("palm",      100, 300, 100, 300, 350, 1001, 4, 2, 1, 1);
    vecs[1]  = mk("fist_x3",   100, 300, 100, 300, 100, 1002, 3, 2, 0, 0);
    vecs[2]  = mk("fist_4th",  100, 300, 100, 300, 100, 1003, 1, 1, 1, 1);
    vecs[3]  = mk("narrow_w",  100, 130, 100, 300, 100, 1004, 4, 0, 1, 1);
    vecs[4]  = mk("inverted",  200, 100, 100, 300, 100, 1005, 4, 0, 0, 1);
    vecs[5]  = mk("min_box",   100, 140, 100, 140,   0, 1006, 4, 1, 1, 1);
    vecs[6]  = mk("point_eq",  100, 140,   0, 100, 500, 1007, 4, 3, 1, 1);
    vecs[7]  = mk("below_pt",  100, 140,   0,  99, 500, 1008, 4, 2, 1, 1);
    vecs[8]  = mk("short_h",     0, 100,   0,  39, 500, 1009, 4, 0, 1, 1);
    vecs[9]  = mk("flat_y",      0, 100,  50,  50, 500, 1010, 4, 0, 0, 1);
    vecs[10] = mk("palm_th",   100, 300, 100, 300, 300, 1011, 4, 2, 1, 1);

    // Reset held with a live strobe on the bus
    rst   = 1'b1;
    vsync = 1'b0;
    box_bus.box_valid = 1'b1;
    box_bus.x_min = 12'd100; box_bus.x_max = 12'd300;
    box_bus.y_min = 12'd100; box_bus.y_max = 12'd300;
    box_bus.fingertip = 20'd350; box_bus.box_area = 20'd77;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_code", gesture_code, 0);
      check("rst_change", gesture_change, 0);
      check("rst_stable", gesture_stable, 0);
    end
    rst = 1'b0;
    box_bus.box_valid = 1'b0;
    tick();
    check("rst_area", gesture_area, 0);

    // POINT latency: code appears 3 cycles after the 4th strobe
    p0 = n_pulse;
    send_frames(100, 160, 50, 300, 100, 2001, 4);
    check("lat_t1_code", gesture_code, 0);
    tick();
    check("lat_t2_code", gesture_code, 0);
    check("lat_t2_change", gesture_change, 0);
    tick();
    check("lat_t3_code", gesture_code, 3);
    check("lat_t3_change", gesture_change, 1);
    tick();
    check("lat_t4_change", gesture_change, 0);
    check("lat_stable", gesture_stable, 1);
    check("lat_area", gesture_area, 2001);
    check("lat_pulses", n_pulse - p0, 1);
    exp_area = 2001;

    // Classification/debounce table
    for (int i = 0; i < 11; i++) begin
      p0 = n_pulse;
      send_frames(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].ft, vecs[i].area,
                  vecs[i].reps);
      repeat (5) tick();
      if (vecs[i].pulses > 0) exp_area = vecs[i].area;
      check({vecs[i].name, "_code"}, gesture_code, vecs[i].code);
      check({vecs[i].name, "_pulses"}, n_pulse - p0, vecs[i].pulses);
      check({vecs[i].name, "_stable"}, gesture_stable, vecs[i].stable);
      check({vecs[i].name, "_area"}, gesture_area, exp_area);
    end

    // Timeout from PALM: 7 edges hold, 8th forces NONE once, 9th is quiet
    p0 = n_pulse;
    repeat (7) vsync_pulse();
    check("to7_code", gesture_code, 2);
    check("to7_pulses", n_pulse - p0, 0);
    vsync_pulse();
    repeat (2) tick();
    check("to8_code", gesture_code, 0);
    check("to8_pulses", n_pulse - p0, 1);
    check("to8_stable", gesture_stable, 0);
    check("to8_area", gesture_area, exp_area);
    vsync_pulse();
    repeat (2) tick();
    check("to9_code", gesture_code, 0);
    check("to9_pulses", n_pulse - p0, 1);

    // Accept coinciding with the 8th edge clears the frame counter
    send_frames(100, 300, 100, 300, 350, 1012, 4);
    repeat (5) tick();
    check("col_setup_code", gesture_code, 2);
    check("col_setup_area", gesture_area, 1012);
    p0 = n_pulse;
    repeat (7) vsync_pulse();
    send_frames(100, 300, 100, 300, 350, 1013, 1);
    tick();
    vsync = 1'b1;   // rises in the cycle the frame is in S3
    tick();
    tick();
    vsync = 1'b0;
    repeat (6) tick();
    check("col_code", gesture_code, 2);
    check("col_pulses", n_pulse - p0, 0);
    check("col_area", gesture_area, 1012);
    repeat (7) vsync_pulse();
    check("col_7_code", gesture_code, 2);
    vsync_pulse();
    repeat (2) tick();
    check("col_8_code", gesture_code, 0);
    check("col_8_pulses", n_pulse - p0, 1);

    // Reset mid-pipeline discards in-flight frames
    p0 = n_pulse;
    send_frames(100, 300, 100, 300, 350, 1014, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_code", gesture_code, 0);
    check("midrst_pulses", n_pulse - p0, 0);
    check("midrst_stable", gesture_stable, 0);
    check("midrst_area", gesture_area, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
